// File: rtl/czono_serializer_if.sv
// Constrained-zonotope source bundle: dimensions plus center c, generators g, constraint rows a, rhs b.
interface czono_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NMAX       = 10,
    parameter int unsigned NGMAX      = 5,
    parameter int unsigned NCMAX      = 3
);
    logic [7:0]            n;
    logic [7:0]            ng;
    logic [7:0]            nc;
    logic [DATA_WIDTH-1:0] c [NMAX];
    logic [DATA_WIDTH-1:0] g [NMAX][NGMAX];
    logic [DATA_WIDTH-1:0] a [NCMAX][NGMAX];
    logic [DATA_WIDTH-1:0] b [NCMAX];

    modport src (output n, ng, nc, c, g, a, b);
    modport snk (input  n, ng, nc, c, g, a, b);
endinterface

// File: rtl/czono_serializer.sv
// Streams a constrained zonotope as a valid/ready frame: header, c, G (row-major), A (row-major), b.
module czono_serializer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NMAX       = 10,
    parameter int unsigned NGMAX      = 5,
    parameter int unsigned NCMAX      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    czono_if.snk                  Z,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int unsigned RMAX      = (NMAX > NCMAX) ? NMAX : NCMAX;
    localparam int unsigned RW        = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int unsigned CW        = (NGMAX > 1) ? $clog2(NGMAX) : 1;
    localparam int unsigned CIW       = (NMAX > 1) ? $clog2(NMAX) : 1;
    localparam int unsigned AIW       = (NCMAX > 1) ? $clog2(NCMAX) : 1;
    localparam int unsigned FRAME_MAX = 1 + NMAX + NMAX * NGMAX + NCMAX * NGMAX + NCMAX;
    localparam int unsigned LW        = $clog2(FRAME_MAX + 1);

    typedef enum logic [2:0] {IDLE, HDR, CEN, GEN, CON, RHS, DONE} state_t;

    state_t          state;
    logic [7:0]      n_q, ng_q, nc_q;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [LW-1:0]   rem;

    state_t          nxt_state;
    logic [RW-1:0]   nxt_row;
    logic [CW-1:0]   nxt_col;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [7:0]      row_lim;
    logic            row_more, col_more;
    logic            illegal;
    logic [31:0]     frame_len;

    assign illegal   = (Z.n == 8'd0) || (32'(Z.n) > NMAX) || (32'(Z.ng) > NGMAX) || (32'(Z.nc) > NCMAX);
    assign frame_len = 32'd1 + 32'(Z.n) + 32'(Z.n) * 32'(Z.ng) + 32'(Z.nc) * 32'(Z.ng) + 32'(Z.nc);

    assign row_lim  = (state == CON || state == RHS) ? nc_q : n_q;
    assign row_more = (16'(row) + 16'd1) < 16'(row_lim);
    assign col_more = (16'(col) + 16'd1) < 16'(ng_q);

    // Position of the word following the one on the bus; the remaining-word count ends the frame.
    always_comb begin
        nxt_state = state;
        nxt_row   = row;
        nxt_col   = col;
        case (state)
            HDR: begin
                nxt_state = CEN;
                nxt_row   = '0;
                nxt_col   = '0;
            end
            CEN: begin
                if (row_more) begin
                    nxt_row = row + RW'(1);
                end else begin
                    nxt_state = (ng_q != 8'd0) ? GEN : RHS;
                    nxt_row   = '0;
                    nxt_col   = '0;
                end
            end
            GEN, CON: begin
                if (col_more) begin
                    nxt_col = col + CW'(1);
                end else if (row_more) begin
                    nxt_col = '0;
                    nxt_row = row + RW'(1);
                end else begin
                    nxt_state = (state == GEN) ? CON : RHS;
                    nxt_row   = '0;
                    nxt_col   = '0;
                end
            end
            RHS: nxt_row = row + RW'(1);
            default: ;
        endcase
    end

    always_comb begin
        nxt_data = '0;
        case (nxt_state)
            CEN:     nxt_data = Z.c[CIW'(nxt_row)];
            GEN:     nxt_data = Z.g[CIW'(nxt_row)][nxt_col];
            CON:     nxt_data = Z.a[AIW'(nxt_row)][nxt_col];
            RHS:     nxt_data = Z.b[AIW'(nxt_row)];
            default: nxt_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            n_q       <= '0;
            ng_q      <= '0;
            nc_q      <= '0;
            row       <= '0;
            col       <= '0;
            rem       <= '0;
            busy_o    <= 1'b0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            state     <= HDR;
                            n_q       <= Z.n;
                            ng_q      <= Z.ng;
                            nc_q      <= Z.nc;
                            row       <= '0;
                            col       <= '0;
                            rem       <= LW'(frame_len);
                            busy_o    <= 1'b1;
                            m_valid_o <= 1'b1;
                            m_data_o  <= DATA_WIDTH'({8'h5A, Z.nc, Z.ng, Z.n});
                            m_last_o  <= 1'b0;
                        end
                    end
                end
                HDR, CEN, GEN, CON, RHS: begin
                    if (m_valid_o && m_ready_i) begin
                        if (m_last_o) begin
                            state     <= DONE;
                            m_valid_o <= 1'b0;
                            m_last_o  <= 1'b0;
                            m_data_o  <= '0;
                            done_o    <= 1'b1;
                        end else begin
                            state    <= nxt_state;
                            row      <= nxt_row;
                            col      <= nxt_col;
                            m_data_o <= nxt_data;
                            rem      <= rem - LW'(1);
                            m_last_o <= (rem == LW'(2));
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_czono_serializer.sv
// Directed bench for czono_serializer: a frame model built from the zonotope contents is checked every transfer.
module tb_czono_serializer;
    logic        clk;
    logic        rst;
    logic        start;
    logic        m_ready;
    logic        busy_o, m_valid_o, m_last_o, done_o, err_o;
    logic [31:0] m_data_o;

    czono_if #(.DATA_WIDTH(32), .NMAX(10), .NGMAX(5), .NCMAX(3)) zif ();

    czono_serializer #(.DATA_WIDTH(32), .NMAX(10), .NGMAX(5), .NCMAX(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .Z         (zif),
        .start_i   (start),
        .busy_o    (busy_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int   words_seen, valid_cycles, busy_cycles, done_seen, err_seen;
    logic mon_en, stall_prev, last_prev, held_last;
    logic [31:0] held_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic set_z(input int n, input int ng, input int nc);
        zif.n  = 8'(n);
        zif.ng = 8'(ng);
        zif.nc = 8'(nc);
        for (int i = 0; i < 10; i++) begin
            zif.c[i] = 32'h1000_0000 | 32'(i);
            for (int j = 0; j < 5; j++) zif.g[i][j] = 32'h2000_0000 | 32'(i << 8) | 32'(j);
        end
        for (int k = 0; k < 3; k++) begin
            zif.b[k] = 32'h4000_0000 | 32'(k);
            for (int j = 0; j < 5; j++) zif.a[k][j] = 32'h3000_0000 | 32'(k << 8) | 32'(j);
        end
    endtask

    // Expected frame straight from the section ordering rules.
    task automatic build_expected();
        int n, ng, nc;
        n  = int'(zif.n);
        ng = int'(zif.ng);
        nc = int'(zif.nc);
        exp_q.delete();
        exp_q.push_back({8'h5A, zif.nc, zif.ng, zif.n});
        for (int i = 0; i < n; i++) exp_q.push_back(zif.c[i]);
        for (int i = 0; i < n; i++) for (int j = 0; j < ng; j++) exp_q.push_back(zif.g[i][j]);
        for (int k = 0; k < nc; k++) for (int j = 0; j < ng; j++) exp_q.push_back(zif.a[k][j]);
        for (int k = 0; k < nc; k++) exp_q.push_back(zif.b[k]);
    endtask

    task automatic clear_mon();
        words_seen = 0; valid_cycles = 0; busy_cycles = 0; done_seen = 0; err_seen = 0;
        stall_prev = 1'b0; last_prev = 1'b0; held_last = 1'b0; held_data = '0;
        got_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy_o) busy_cycles++;
            if (stall_prev) begin
                check("stall_valid", 64'(m_valid_o), 64'(1));
                check("stall_data", 64'(m_data_o), 64'(held_data));
                check("stall_last", 64'(m_last_o), 64'(held_last));
            end
            stall_prev = m_valid_o && !m_ready;
            held_data  = m_data_o;
            held_last  = m_last_o;
            if (done_o) begin
                done_seen++;
                check("done_after_last", 64'(last_prev), 64'(1));
                check("done_valid_low", 64'(m_valid_o), 64'(0));
                check("done_word_count", 64'(words_seen), 64'(exp_q.size()));
            end
            last_prev = 1'b0;
            if (err_o) err_seen++;
            if (m_valid_o) begin
                valid_cycles++;
                if (m_ready) begin
                    if (words_seen < exp_q.size()) begin
                        check("data", 64'(m_data_o), 64'(exp_q[words_seen]));
                        check("last", 64'(m_last_o), 64'(words_seen == exp_q.size() - 1));
                    end else begin
                        check("extra_word", 64'(words_seen), 64'(exp_q.size()));
                    end
                    got_q.push_back(m_data_o);
                    words_seen++;
                    last_prev = m_last_o;
                end
            end
        end
    end

    task automatic chk_got(input string name, input int idx, input logic [31:0] req);
        if (idx < got_q.size()) check(name, 64'(got_q[idx]), 64'(req));
        else check(name, 64'(got_q.size()), 64'(idx + 1));
    endtask

    // mode 0: ready held high; 1: toggling 1/0; 2: two-of-three pattern.
    task automatic run_frame(input int mode, input int rst_after, input int restart_at);
        int cyc;
        cyc = 0;
        build_expected();
        clear_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b1;
        check("first_valid", 64'(m_valid_o), 64'(1));
        check("busy_after_start", 64'(busy_o), 64'(1));
        while (done_seen == 0 && cyc < 400) begin
            if (rst_after > 0 && words_seen >= rst_after) break;
            @(posedge clk); #1;
            cyc++;
            case (mode)
                1:       m_ready = ~m_ready;
                2:       m_ready = (cyc % 3) != 1;
                default: m_ready = 1'b1;
            endcase
            start = (cyc == restart_at);
        end
        start = 1'b0;
        if (rst_after == 0) check("frame_timeout", 64'(cyc < 400), 64'(1));
    endtask

    task automatic frame_tail(input string name, input int vcycles);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({name, "_words"}, 64'(words_seen), 64'(exp_q.size()));
        check({name, "_done"}, 64'(done_seen), 64'(1));
        check({name, "_busy_span"}, 64'(busy_cycles), 64'(valid_cycles + 1));
        check({name, "_no_err"}, 64'(err_seen), 64'(0));
        if (vcycles > 0) check({name, "_valid_cycles"}, 64'(valid_cycles), 64'(vcycles));
    endtask

    task automatic run_err(input string name);
        exp_q.delete();
        clear_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_err_pulse"}, 64'(err_o), 64'(1));
        check({name, "_busy"}, 64'(busy_o), 64'(0));
        @(posedge clk); #1;
        check({name, "_err_one_cycle"}, 64'(err_o), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check({name, "_no_valid"}, 64'(valid_cycles), 64'(0));
        check({name, "_no_busy"}, 64'(busy_cycles), 64'(0));
        check({name, "_err_count"}, 64'(err_seen), 64'(1));
    endtask

    task automatic load_req033();
        set_z(2, 3, 1);
        zif.c[0] = 32'h40A0_0000;
        zif.c[1] = 32'h3F00_0000;
        zif.b[0] = 32'h3F80_0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; mon_en = 1'b0;
        clear_mon();
        set_z(2, 3, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_valid", 64'(m_valid_o), 64'(0));
        check("rst_last", 64'(m_last_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_data", 64'(m_data_o), 64'(0));
        rst = 1'b0;

        // Basic 13-word frame, ready held high.
        load_req033();
        run_frame(0, 0, 0);
        frame_tail("full_rate", 13);
        check("full_rate_len", 64'(got_q.size()), 64'(13));
        chk_got("full_rate_hdr", 0, 32'h5A01_0302);
        chk_got("full_rate_w2", 1, 32'h40A0_0000);
        chk_got("full_rate_w13", 12, 32'h3F80_0000);

        // Same frame, ready toggling: 25 valid cycles.
        run_frame(1, 0, 0);
        frame_tail("toggle", 25);
        chk_got("toggle_w13", 12, 32'h3F80_0000);

        // No constraints: header, c, G only.
        set_z(2, 2, 0);
        run_frame(0, 0, 0);
        frame_tail("nc0", 7);
        chk_got("nc0_hdr", 0, 32'h5A00_0202);
        chk_got("nc0_last_g11", 6, 32'h2000_0101);

        // Illegal dimensions.
        set_z(2, 6, 1);
        run_err("ng6");
        set_z(0, 2, 1);
        run_err("n0");
        set_z(11, 1, 1);
        run_err("n11");
        set_z(2, 1, 4);
        run_err("nc4");

        // Reset after word 5, then a fresh frame.
        load_req033();
        run_frame(0, 5, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 64'(m_valid_o), 64'(0));
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(done_seen), 64'(0));
        run_frame(0, 0, 0);
        frame_tail("after_rst", 13);

        // Start pulsed mid-frame is ignored.
        run_frame(0, 0, 4);
        frame_tail("restart", 13);

        // Largest legal frame with a stalling sink.
        set_z(10, 5, 3);
        run_frame(2, 0, 0);
        frame_tail("max", 0);
        check("max_len", 64'(got_q.size()), 64'(79));
        chk_got("max_hdr", 0, 32'h5A03_050A);

        // No generators: header, c, b.
        set_z(3, 0, 2);
        run_frame(0, 0, 0);
        frame_tail("ng0", 6);
        chk_got("ng0_b0", 4, 32'h4000_0000);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
